// File: rtl/shift_add_mult4.sv
// shift_add_mult4: 4x4 unsigned sequential shift-and-add multiplier.
//
// Each operation loads M (multiplicand), Q (multiplier), ACC = 0 and COUNT = 4.
// Every RUN step conditionally adds M into ACC through a 4-bit ripple-carry
// adder, then shifts {C, ACC, Q} right by one bit. When COUNT reaches 0 the
// block enters DONE, registers {ACC, Q} as the product and pulses done.
//
// Timing for a start accepted at edge T:
//   - busy is registered. It is high after edges T+1..T+4, one per add/shift step.
//   - DONE is entered at edge T+5. done is high for that one cycle and product
//     is valid from then on.
//   - The first RUN cycle after acceptance has COUNT = 4. It only lets the
//     loaded operands settle before the first step at edge T+1.
//
// Optional feature macro: ZERO_BYPASS_EN
//   When it is defined, a start with a == 0 or b == 0 is loaded with COUNT = 0
//   and Q = 0. The block then reaches DONE at edge T+1 with product 8'h00, and
//   busy is never asserted. When it is undefined, zero operands take the full
//   RUN path.

module shift_add_mult4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] acc_q, acc_d;
  logic [2:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic [7:0] product_q, product_d;

  // Adder and datapath intermediates.
  logic [3:0] add_sum;
  logic [4:0] add_carry;
  logic [4:0] acc_sel;   // {C, ACC} chosen by Q[0]
  logic       accept;

  // 4-bit ripple-carry adder ACC + M with cin = 0, built from explicit full adders.
  always_comb begin
    add_sum      = 4'd0;
    add_carry    = 5'd0;
    add_carry[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      add_sum[i]     = acc_q[i] ^ m_q[i] ^ add_carry[i];
      add_carry[i+1] = (acc_q[i] & m_q[i]) | (add_carry[i] & (acc_q[i] ^ m_q[i]));
    end
  end

  // Select the add result or the unchanged accumulator, depending on the multiplier LSB.
  always_comb begin
    acc_sel = 5'd0;
    if (q_q[0]) begin
      acc_sel = {add_carry[4], add_sum};
    end else begin
      acc_sel = {1'b0, acc_q};
    end
  end

  // A new operation may start only from IDLE or DONE; start is ignored during RUN.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and datapath update logic.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          m_d     = a;
          q_d     = b;
          acc_d   = 4'd0;
          count_d = 3'd4;
          state_d = RUN;
`ifdef ZERO_BYPASS_EN
          // Zero operand: skip the add/shift steps. Q is cleared so {ACC, Q} is 0.
          if ((a == 4'd0) || (b == 4'd0)) begin
            q_d     = 4'd0;
            count_d = 3'd0;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (count_q == 3'd0) begin
          state_d   = DONE;
          product_d = {acc_q, q_q};
        end else begin
          // Shift {C, ACC, Q} right by one bit.
          acc_d   = acc_sel[4:1];
          q_d     = {acc_sel[0], q_q[3:1]};
          count_d = count_q - 3'd1;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
  // NOTE: every register here is a plain flop, so each one is cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= 4'd0;
      q_q       <= 4'd0;
      acc_q     <= 4'd0;
      count_q   <= 3'd0;
      busy_q    <= 1'b0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult4.sv
// Testbench for shift_add_mult4.
// The reference model tracks each accepted operation by its age in cycles
// and the product a*b. It follows the latency rules of the design:
//   - busy is expected after edges T+1..T+4.
//   - done and the new product are expected after edge T+5.
//   - With ZERO_BYPASS_EN and a zero operand, done is expected after edge T+1.

module tb_shift_add_mult4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

`ifdef ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_add_mult4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  bit         m_active   = 1'b0;
  bit         m_accepted = 1'b0;
  int         m_age      = 0;
  int         m_lat      = 0;
  logic [7:0] m_pend     = 8'h00;
  logic [7:0] exp_product = 8'h00;
  logic       exp_busy    = 1'b0;
  logic       exp_done    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one rising edge, using the inputs applied at that edge.
  function automatic void model_edge();
    m_accepted = 1'b0;
    if (!rst_n) begin
      m_active    = 1'b0;
      exp_product = 8'h00;
      exp_busy    = 1'b0;
      exp_done    = 1'b0;
    end else if (m_active) begin
      m_age++;
      exp_done = 1'b0;
      if (m_age == m_lat) begin
        m_active    = 1'b0;
        exp_done    = 1'b1;
        exp_product = m_pend;
      end
      exp_busy = m_active && (m_lat == 5) && (m_age >= 1) && (m_age <= 4);
    end else begin
      exp_done = 1'b0;
      exp_busy = 1'b0;
      if (start) begin
        m_active   = 1'b1;
        m_accepted = 1'b1;
        m_age      = 0;
        m_lat      = (BYPASS && ((a == 4'd0) || (b == 4'd0))) ? 1 : 5;
        m_pend     = 8'(a) * 8'(b);
      end
    end
  endfunction

  // Apply inputs at the falling edge, clock once, then check the outputs 1 time unit after the edge.
  task automatic cycle(input logic r, input logic s, input logic [3:0] x, input logic [3:0] y,
                       input string tag);
    rst_n = r;
    start = s;
    a     = x;
    b     = y;
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".product"}, 32'(product), 32'(exp_product));
    @(negedge clk);
  endtask

  initial begin
    int dc;
    int idx;
    int guard;

    rst_n = 1'b0;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    @(negedge clk);

    // Reset with start asserted: start must be ignored.
    repeat (3) cycle(1'b0, 1'b1, 4'hF, 4'hF, "reset");
    check("reset.product_zero", 32'(product), 32'h0);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, "idle");

    // a=8, b=8 with a one-cycle start.
    cycle(1'b1, 1'b1, 4'd8, 4'd8, "r27");
    repeat (4) cycle(1'b1, 1'b0, 4'd0, 4'd0, "r27");
    cycle(1'b1, 1'b0, 4'd0, 4'd0, "r27");
    check("r27.done_at_t5", 32'(done), 32'd1);
    check("r27.prod", 32'(product), 32'h40);
    repeat (2) cycle(1'b1, 1'b0, 4'd0, 4'd0, "r27");

    // Start held high: 15*15, then 8*15 accepted back-to-back from DONE.
    cycle(1'b1, 1'b1, 4'd15, 4'd15, "r28");
    repeat (5) cycle(1'b1, 1'b1, 4'd8, 4'd15, "r28");
    check("r28.prod1", 32'(product), 32'hE1);
    check("r28.done1", 32'(done), 32'd1);
    cycle(1'b1, 1'b1, 4'd8, 4'd15, "r28");
    repeat (4) cycle(1'b1, 1'b0, 4'd0, 4'd0, "r28");
    cycle(1'b1, 1'b0, 4'd0, 4'd0, "r28");
    check("r28.prod2", 32'(product), 32'h78);
    check("r28.done2", 32'(done), 32'd1);
    repeat (2) cycle(1'b1, 1'b0, 4'd0, 4'd0, "r28");

    // A start during RUN must be ignored.
    cycle(1'b1, 1'b1, 4'd2, 4'd8, "r29");
    cycle(1'b1, 1'b0, 4'd0, 4'd0, "r29");
    cycle(1'b1, 1'b1, 4'd15, 4'd15, "r29");
    repeat (2) cycle(1'b1, 1'b0, 4'd0, 4'd0, "r29");
    cycle(1'b1, 1'b0, 4'd0, 4'd0, "r29");
    check("r29.prod", 32'(product), 32'h10);
    dc = 0;
    repeat (6) begin
      cycle(1'b1, 1'b0, 4'd0, 4'd0, "r29");
      dc += int'(done);
    end
    check("r29.no_second_done", 32'(dc), 32'd0);

    // Reset in the middle of RUN, then a normal restart.
    cycle(1'b1, 1'b1, 4'd9, 4'd7, "r30");
    repeat (2) cycle(1'b1, 1'b0, 4'd0, 4'd0, "r30");
    cycle(1'b0, 1'b0, 4'd0, 4'd0, "r30");
    check("r30.busy_cleared", 32'(busy), 32'd0);
    check("r30.prod_cleared", 32'(product), 32'h0);
    cycle(1'b1, 1'b1, 4'd3, 4'd5, "r30");
    repeat (4) cycle(1'b1, 1'b0, 4'd0, 4'd0, "r30");
    cycle(1'b1, 1'b0, 4'd0, 4'd0, "r30");
    check("r30.prod", 32'(product), 32'h0F);
    check("r30.done", 32'(done), 32'd1);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, "r30");

    // Zero operand: done at T+1 with bypass, T+5 without.
    cycle(1'b1, 1'b1, 4'd0, 4'd13, "r31");
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, 1'b0, 4'd0, 4'd0, "r31");
      if (k == (BYPASS ? 1 : 5)) begin
        check("r31.done", 32'(done), 32'd1);
        check("r31.prod", 32'(product), 32'h0);
      end
    end
    repeat (2) cycle(1'b1, 1'b0, 4'd0, 4'd0, "r31");

    // Exhaustive back-to-back sweep of all 256 pairs; operands and start are random while busy.
    idx   = 0;
    guard = 0;
    while ((idx < 256) && (guard < 4000)) begin
      if (m_active) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), "sweep");
      end else begin
        cycle(1'b1, 1'b1, 4'(idx >> 4), 4'(idx), "sweep");
        if (m_accepted) idx++;
      end
      guard++;
    end
    check("sweep.pairs_accepted", 32'(idx), 32'd256);
    repeat (7) cycle(1'b1, 1'b0, 4'd0, 4'd0, "sweep");

    // Fully random traffic with occasional resets.
    repeat (400) begin
      cycle(1'($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
